pattern_seq_gen: RTL

Parametrised serial pattern generator producing a single-bit output stream `y` from a loadable pattern register. It is the next generation of the Activity 3 clock-driven `y` generator. It adds a configurable width, programmable length, and three modes: one-shot, repeat and LFSR pseudo-random. It also adds load/start/stop control, pause, and status outputs. It sits directly under the lab testbench/top level and is driven from the free-running `clk`.

---
 rtl/pattern_seq_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pattern_seq_gen.sv
// ---------------------------------------------------------------------------
// pattern_seq_gen
//
// Serial pattern generator that shifts a loadable pattern out on a single
// registered output bit. Three modes are supported:
//   00 one-shot : emit len_q bits of the pattern once, then return to IDLE
//   01 repeat   : emit len_q bits of the pattern over and over
//   10 LFSR     : emit a pseudo-random stream from a right-shifting LFSR
//   11 reserved : handled exactly like one-shot
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   load     in   capture pattern/len/mode into shadow registers (IDLE only)
//   pattern  in   WIDTH-bit pattern, or LFSR seed; bit 0 is emitted first
//   len      in   number of bits to emit; 0 or >WIDTH is stored as WIDTH
//   mode     in   operating mode (see above)
//   start    in   begin emission (IDLE only); may share a cycle with load
//   stop     in   abort emission (RUN only), no done pulse
//   en       in   step enable while running; low holds all state
//   y        out  serial output bit
//   busy     out  high while running
//   done     out  one-cycle pulse at sequence end, pattern wrap or LFSR wrap
//   bit_idx  out  index of the bit currently on y (0 in LFSR mode)
// ---------------------------------------------------------------------------
module pattern_seq_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter int               LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [LW-1:0]    bit_idx
);

    localparam logic [1:0]       MODE_ONESHOT = 2'b00;
    localparam logic [1:0]       MODE_REPEAT  = 2'b01;
    localparam logic [1:0]       MODE_LFSR    = 2'b10;
    localparam logic [LW-1:0]    LEN_MAX      = LW'(WIDTH);
    localparam logic [WIDTH-1:0] SEED_ONE     = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;

    // Shadow registers holding the configuration of the current/next run
    logic [WIDTH-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] lfsr_q;

    // Sanitised versions of the raw inputs, as they would be stored
    logic [1:0]       in_mode;
    logic [LW-1:0]    in_len;
    logic [WIDTH-1:0] in_seed;
    logic [WIDTH-1:0] in_pat;

    // Configuration seen by a start; load in the same cycle bypasses the
    // shadow registers so the new values take effect immediately
    logic [1:0]       go_mode;
    logic [WIDTH-1:0] go_pat;
    logic [WIDTH-1:0] go_seed;

    // Step helpers
    logic             fb;
    logic [WIDTH-1:0] lfsr_next;
    logic [LW-1:0]    next_idx;
    logic [WIDTH-1:0] pat_shifted;
    logic             last_bit;

    // Clean up the load inputs: reserved mode folds to one-shot, an
    // out-of-range length becomes the full width, and an all-zero seed
    // (which would lock the LFSR) becomes 1. The zero fix is applied to
    // pat_q only in LFSR mode, because a zero pattern is legitimate data
    // for one-shot/repeat. pat_q doubles as the wrap reference for LFSR.
    always_comb begin
        in_mode = (mode == 2'b11) ? MODE_ONESHOT : mode;
        in_len  = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
        in_seed = (pattern == '0) ? SEED_ONE : pattern;
        in_pat  = (in_mode == MODE_LFSR) ? in_seed : pattern;

        go_mode = load ? in_mode : mode_q;
        go_pat  = load ? in_pat  : pat_q;
        go_seed = (go_pat == '0) ? SEED_ONE : go_pat;
    end

    // Next-step values for both the shift-out path and the LFSR path.
    // The pattern is indexed with a shift so the index width never has
    // to match the pattern width exactly.
    always_comb begin
        fb          = ^(lfsr_q & TAPS);
        lfsr_next   = {fb, lfsr_q[WIDTH-1:1]};
        next_idx    = bit_idx + 1'b1;
        pat_shifted = pat_q >> next_idx;
        last_bit    = (bit_idx == len_q - 1'b1);
    end

    // Main state machine. All outputs are registered here; done defaults
    // low every cycle so it can only ever be a single-cycle pulse unless
    // a one-bit repeat sequence wraps on consecutive steps. Stop wins over
    // stepping and is honoured even while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            y       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
            pat_q   <= '0;
            len_q   <= LEN_MAX;
            mode_q  <= MODE_ONESHOT;
            lfsr_q  <= SEED_ONE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        pat_q  <= in_pat;
                        len_q  <= in_len;
                        mode_q <= in_mode;
                        lfsr_q <= in_seed;
                    end
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                        if (go_mode == MODE_LFSR) begin
                            lfsr_q <= go_seed;
                            y      <= go_seed[0];
                        end else begin
                            y <= go_pat[0];
                        end
                    end
                end

                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        y       <= 1'b0;
                        bit_idx <= '0;
                    end else if (en) begin
                        if (mode_q == MODE_LFSR) begin
                            // Wrap is detected on the value being loaded,
                            // so done lines up with the seed reappearing
                            lfsr_q <= lfsr_next;
                            y      <= lfsr_next[0];
                            if (lfsr_next == pat_q) begin
                                done <= 1'b1;
                            end
                        end else if (!last_bit) begin
                            bit_idx <= next_idx;
                            y       <= pat_shifted[0];
                        end else if (mode_q == MODE_REPEAT) begin
                            bit_idx <= '0;
                            y       <= pat_q[0];
                            done    <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            y       <= 1'b0;
                            bit_idx <= '0;
                            done    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    y     <= 1'b0;
                end
            endcase
        end
    end

endmodule
